// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: default widths and opcode encodings.
package alu_pkg;

    localparam int NB_DATA_DEF   = 8;
    localparam int NB_OPCODE_DEF = 6;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus carry/borrow and signed overflow.
module alu_core
    import alu_pkg::*;
#(
    parameter int NB_DATA   = NB_DATA_DEF,
    parameter int NB_OPCODE = NB_OPCODE_DEF
) (
    input  logic [NB_DATA-1:0]   i_op_1,
    input  logic [NB_DATA-1:0]   i_op_2,
    input  logic [NB_OPCODE-1:0] i_opcode,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_carry,
    output logic                 o_overflow
);

    localparam logic [NB_OPCODE-1:0] C_ADD = NB_OPCODE'(OP_ADD);
    localparam logic [NB_OPCODE-1:0] C_SUB = NB_OPCODE'(OP_SUB);
    localparam logic [NB_OPCODE-1:0] C_AND = NB_OPCODE'(OP_AND);
    localparam logic [NB_OPCODE-1:0] C_OR  = NB_OPCODE'(OP_OR);
    localparam logic [NB_OPCODE-1:0] C_XOR = NB_OPCODE'(OP_XOR);
    localparam logic [NB_OPCODE-1:0] C_NOR = NB_OPCODE'(OP_NOR);
    localparam logic [NB_OPCODE-1:0] C_SRA = NB_OPCODE'(OP_SRA);
    localparam logic [NB_OPCODE-1:0] C_SRL = NB_OPCODE'(OP_SRL);

    localparam int MSB = NB_DATA - 1;

    // The extra top bit of sum is the carry-out; of diff it is the borrow.
    logic [NB_DATA:0] sum;
    logic [NB_DATA:0] diff;

    assign sum  = {1'b0, i_op_1} + {1'b0, i_op_2};
    assign diff = {1'b0, i_op_1} - {1'b0, i_op_2};

    // Operation select; undefined opcodes fall through to all-zero outputs.
    always_comb begin
        o_result   = '0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        case (i_opcode)
            C_ADD: begin
                o_result   = sum[NB_DATA-1:0];
                o_carry    = sum[NB_DATA];
                o_overflow = (i_op_1[MSB] == i_op_2[MSB]) && (sum[MSB] != i_op_1[MSB]);
            end
            C_SUB: begin
                o_result   = diff[NB_DATA-1:0];
                o_carry    = diff[NB_DATA];
                o_overflow = (i_op_1[MSB] != i_op_2[MSB]) && (diff[MSB] != i_op_1[MSB]);
            end
            C_AND: o_result = i_op_1 & i_op_2;
            C_OR:  o_result = i_op_1 | i_op_2;
            C_XOR: o_result = i_op_1 ^ i_op_2;
            C_NOR: o_result = ~(i_op_1 | i_op_2);
            // Shift amount is the full unsigned i_op_2, so oversized shifts
            // naturally saturate to sign fill / zero.
            C_SRA: o_result = $signed(i_op_1) >>> i_op_2;
            C_SRL: o_result = i_op_1 >> i_op_2;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// ALU top: combinational result from alu_core, status flags registered here.
module alu
    import alu_pkg::*;
#(
    parameter int NB_DATA   = NB_DATA_DEF,
    parameter int NB_OPCODE = NB_OPCODE_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NB_DATA-1:0]   i_op_1,
    input  logic [NB_DATA-1:0]   i_op_2,
    input  logic [NB_OPCODE-1:0] i_opcode,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_carry,
    output logic                 o_overflow,
    output logic                 o_zero,
    output logic                 o_negative
);

    logic carry_nxt;
    logic overflow_nxt;

    alu_core #(
        .NB_DATA   (NB_DATA),
        .NB_OPCODE (NB_OPCODE)
    ) u_core (
        .i_op_1     (i_op_1),
        .i_op_2     (i_op_2),
        .i_opcode   (i_opcode),
        .o_result   (o_result),
        .o_carry    (carry_nxt),
        .o_overflow (overflow_nxt)
    );

    // Flags sample the live result each edge, so they trail o_result by one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_carry    <= 1'b0;
            o_overflow <= 1'b0;
            o_zero     <= 1'b0;
            o_negative <= 1'b0;
        end else begin
            o_carry    <= carry_nxt;
            o_overflow <= overflow_nxt;
            o_zero     <= (o_result == '0);
            o_negative <= o_result[NB_DATA-1];
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed corner cases, mid-cycle reset and a
// randomized sweep against an arithmetic reference model.
module tb_alu;
    import alu_pkg::*;

    logic       i_clk;
    logic       i_rst_n;
    logic [7:0] i_op_1;
    logic [7:0] i_op_2;
    logic [5:0] i_opcode;
    logic [7:0] o_result;
    logic       o_carry;
    logic       o_overflow;
    logic       o_zero;
    logic       o_negative;

    int tests = 0;
    int fails = 0;

    logic [3:0] prev_flags;
    logic [3:0] exp_flags;
    logic [7:0] exp_res;

    alu dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_op_1     (i_op_1),
        .i_op_2     (i_op_2),
        .i_opcode   (i_opcode),
        .o_result   (o_result),
        .o_carry    (o_carry),
        .o_overflow (o_overflow),
        .o_zero     (o_zero),
        .o_negative (o_negative)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [3:0] flags_now();
        return {o_carry, o_overflow, o_zero, o_negative};
    endfunction

    // Reference model using plain integer arithmetic.
    function automatic void model(input logic [5:0] op, input logic [7:0] a,
                                  input logic [7:0] b, output logic [7:0] res,
                                  output logic [3:0] flg);
        int ua, ub, sa, sb, s, t;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c = 1'b0;
        v = 1'b0;
        res = 8'h00;
        case (op)
            OP_ADD: begin
                s = ua + ub;
                res = s[7:0];
                c = (s > 255);
                t = sa + sb;
                v = (t > 127) || (t < -128);
            end
            OP_SUB: begin
                s = ua - ub;
                res = s[7:0];
                c = (ua < ub);
                t = sa - sb;
                v = (t > 127) || (t < -128);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_NOR: res = ~(a | b);
            OP_SRA: begin
                if (ub >= 8) res = a[7] ? 8'hFF : 8'h00;
                else begin
                    t = sa >>> ub;
                    res = t[7:0];
                end
            end
            OP_SRL: begin
                if (ub >= 8) res = 8'h00;
                else begin
                    t = ua >> ub;
                    res = t[7:0];
                end
            end
            default: res = 8'h00;
        endcase
        flg = {c, v, (res == 8'h00), res[7]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one operation after a falling edge, check the result at once and
    // the flags both before (still old) and after the next rising edge.
    task automatic do_op(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge i_clk);
        i_opcode = op;
        i_op_1   = a;
        i_op_2   = b;
        #1;
        model(op, a, b, exp_res, exp_flags);
        chk($sformatf("result op=%b a=%h b=%h", op, a, b), 32'(o_result), 32'(exp_res));
        chk("flags_hold_before_edge", 32'(flags_now()), 32'(prev_flags));
        @(posedge i_clk);
        #1;
        chk($sformatf("flags op=%b a=%h b=%h", op, a, b), 32'(flags_now()), 32'(exp_flags));
        prev_flags = exp_flags;
    endtask

    // Directed step that also compares against hand-derived constants.
    task automatic do_dir(input string tag, input logic [5:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] res_c,
                          input logic [3:0] flg_c);
        do_op(op, a, b);
        chk({tag, "_res"}, 32'(o_result), 32'(res_c));
        chk({tag, "_flags"}, 32'(flags_now()), 32'(flg_c));
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [7:0] ra, rb;
        logic [5:0] rop;
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR;
        ops[4] = OP_XOR; ops[5] = OP_NOR; ops[6] = OP_SRA; ops[7] = OP_SRL;

        i_rst_n  = 1'b1;
        i_op_1   = 8'h00;
        i_op_2   = 8'h00;
        i_opcode = OP_ADD;
        #2 i_rst_n = 1'b0;
        #1;
        chk("reset_flags", 32'(flags_now()), 32'h0);

        // Result tracks inputs during reset, flags stay clear across an edge.
        i_op_1 = 8'h05;
        i_op_2 = 8'h03;
        #1;
        chk("reset_result_tracks", 32'(o_result), 32'h08);
        @(posedge i_clk);
        #1;
        chk("reset_flags_hold", 32'(flags_now()), 32'h0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        prev_flags = 4'b0000;

        // Flag order: {carry, overflow, zero, negative}
        do_dir("add_5_3",   OP_ADD, 8'h05, 8'h03, 8'h08, 4'b0000);
        do_dir("add_7f_1",  OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0101);
        do_dir("add_ff_1",  OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1010);
        do_dir("sub_3_5",   OP_SUB, 8'h03, 8'h05, 8'hFE, 4'b1001);
        do_dir("sub_80_1",  OP_SUB, 8'h80, 8'h01, 8'h7F, 4'b0100);
        do_dir("nor_f0_0c", OP_NOR, 8'hF0, 8'h0C, 8'h03, 4'b0000);
        do_dir("sra_90_2",  OP_SRA, 8'h90, 8'h02, 8'hE4, 4'b0001);
        do_dir("srl_90_2",  OP_SRL, 8'h90, 8'h02, 8'h24, 4'b0000);
        do_dir("sra_90_9",  OP_SRA, 8'h90, 8'h09, 8'hFF, 4'b0001);
        do_dir("srl_90_9",  OP_SRL, 8'h90, 8'h09, 8'h00, 4'b0010);
        do_dir("sra_70_ff", OP_SRA, 8'h70, 8'hFF, 8'h00, 4'b0010);
        do_dir("undef_3f",  6'b111111, 8'hFF, 8'h01, 8'h00, 4'b0010);

        // Mid-cycle reset: flags clear immediately, result unaffected.
        do_dir("pre_rst", OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1010);
        do_op(OP_SUB, 8'h03, 8'h05);
        #2 i_rst_n = 1'b0;
        #1;
        chk("midrst_flags", 32'(flags_now()), 32'h0);
        chk("midrst_result", 32'(o_result), 32'hFE);
        @(posedge i_clk);
        #1;
        chk("midrst_hold", 32'(flags_now()), 32'h0);
        #2 i_rst_n = 1'b1;
        prev_flags = 4'b0000;
        do_dir("post_rst", OP_SUB, 8'h03, 8'h05, 8'hFE, 4'b1001);

        // Random sweep over all defined opcodes.
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i % 4 == 0) rb = 8'($urandom_range(0, 10));
            for (int k = 0; k < 8; k++) do_op(ops[k], ra, rb);
        end

        // A few arbitrary opcodes, including undefined ones.
        for (int i = 0; i < 20; i++) begin
            rop = 6'($urandom_range(0, 63));
            do_op(rop, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
